// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int N_MIN     = 2;
    localparam int W_DEFAULT = 32;

endpackage

// File: rtl/div_counter.sv
// Period counter: counts 0..n_act-1, flags the last cycle and drives the registered divided clock.
module div_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         active,
    input  logic         stop,
    input  logic [W-1:0] n_act,
    input  logic [W-1:0] n_next,
    output logic         tick,
    output logic         n_clk
);

    localparam logic [W-1:0] ONE_W = W'(1);

    logic [W-1:0] cnt_reg;
    logic         n_clk_reg;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] n_half;
    logic [W-1:0] n_next_half;

    // cnt never exceeds n_act-1, so the increment cannot wrap even at 2^W-1
    assign cnt_inc     = cnt_reg + ONE_W;
    assign n_half      = n_act >> 1;
    assign n_next_half = n_next >> 1;
    assign tick        = active && (cnt_reg == (n_act - ONE_W));
    assign n_clk       = n_clk_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            n_clk_reg <= 1'b0;
        end else if (start) begin
            cnt_reg   <= '0;
            n_clk_reg <= (n_half != '0);
        end else if (active) begin
            if (tick) begin
                cnt_reg   <= '0;
                n_clk_reg <= !stop && (n_next_half != '0);
            end else begin
                cnt_reg   <= cnt_inc;
                n_clk_reg <= (cnt_inc < n_half);
            end
        end else begin
            cnt_reg   <= '0;
            n_clk_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: run/stop FSM and ratio handshake; new ratios take effect only at a period boundary.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int N_RESET = 7,
    parameter int W       = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_n,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         n_clk,
    output logic         tick,
    output logic         busy
);

    localparam logic [W-1:0] N_RESET_W = W'(N_RESET);
    localparam logic [W-1:0] N_MIN_W   = W'(N_MIN);

    state_t       state_reg;
    logic [W-1:0] n_act_reg;
    logic [W-1:0] shadow_reg;
    logic         cfg_err_reg;
    logic         xfer;
    logic         legal;
    logic         start;
    logic         active;
    logic [W-1:0] n_next;

    assign cfg_ready = (state_reg != PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (cfg_n >= N_MIN_W);
    assign start     = (state_reg == OFF) && en;
    assign active    = (state_reg != OFF);
    assign busy      = active;
    assign cfg_err   = cfg_err_reg;
    assign n_next    = (state_reg == PEND) ? shadow_reg : n_act_reg;

    div_counter #(
        .W(W)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .active (active),
        .stop   (!en),
        .n_act  (n_act_reg),
        .n_next (n_next),
        .tick   (tick),
        .n_clk  (n_clk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= OFF;
            n_act_reg   <= N_RESET_W;
            shadow_reg  <= N_RESET_W;
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= xfer && !legal;
            case (state_reg)
                OFF: begin
                    if (xfer && legal)
                        n_act_reg <= cfg_n;
                    if (en)
                        state_reg <= RUN;
                end
                RUN: begin
                    // Stopping at this boundary: there is no later tick, so a ratio taken now applies directly
                    if (tick && !en) begin
                        state_reg <= OFF;
                        if (xfer && legal)
                            n_act_reg <= cfg_n;
                    end else if (xfer && legal) begin
                        shadow_reg <= cfg_n;
                        state_reg  <= PEND;
                    end
                end
                PEND: begin
                    if (tick) begin
                        n_act_reg <= shadow_reg;
                        state_reg <= en ? RUN : OFF;
                    end
                end
                default: state_reg <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a vector table for steady running plus hand sequences for boundary cases.
module tb_clk_div_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_n = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         n_clk;
    logic         tick;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    // expected output order: {n_clk, tick, busy, cfg_ready, cfg_err}
    typedef struct {
        logic       en;
        logic       cv;
        logic [7:0] n;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[26];

    clk_div_ctrl #(.N_RESET(7), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .n_clk     (n_clk),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {n_clk, tick, busy, cfg_ready, cfg_err};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {n_clk,tick,busy,rdy,err}=%b required %b at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %b at %0t", name, act, $time);
        end
    endtask

    // apply inputs for one clock, then check outputs just after the edge
    task automatic cyc(input logic e, input logic cv, input logic [7:0] n,
                       input logic [4:0] exp, input string name);
        en        = e;
        cfg_valid = cv;
        cfg_n     = W'(n);
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #2;
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        check(name, 5'b00010);
        rst = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic e, input logic cv,
                           input logic [7:0] n, input logic [4:0] exp);
        vecs[i].en  = e;
        vecs[i].cv  = cv;
        vecs[i].n   = n;
        vecs[i].exp = exp;
    endtask

    initial begin
        // default run at 7, illegal ratios 1 and 0, ratio 4 queued at cnt 2, ignored offer while pending
        set_vec( 0, 1, 0, 0, 5'b10110);  // cnt0
        set_vec( 1, 1, 0, 0, 5'b10110);  // cnt1
        set_vec( 2, 1, 0, 0, 5'b10110);  // cnt2
        set_vec( 3, 1, 0, 0, 5'b00110);  // cnt3
        set_vec( 4, 1, 0, 0, 5'b00110);
        set_vec( 5, 1, 0, 0, 5'b00110);
        set_vec( 6, 1, 0, 0, 5'b01110);  // cnt6 tick
        set_vec( 7, 1, 0, 0, 5'b10110);  // cnt0
        set_vec( 8, 1, 1, 1, 5'b10111);  // cnt1, err for n=1
        set_vec( 9, 1, 1, 0, 5'b10111);  // cnt2, err for n=0
        set_vec(10, 1, 0, 0, 5'b00110);  // cnt3
        set_vec(11, 1, 0, 0, 5'b00110);
        set_vec(12, 1, 0, 0, 5'b00110);
        set_vec(13, 1, 0, 0, 5'b01110);  // cnt6 tick, ratio still 7
        set_vec(14, 1, 0, 0, 5'b10110);
        set_vec(15, 1, 0, 0, 5'b10110);
        set_vec(16, 1, 0, 0, 5'b10110);  // cnt2
        set_vec(17, 1, 1, 4, 5'b00100);  // cnt3, PEND
        set_vec(18, 1, 1, 9, 5'b00100);  // offer ignored
        set_vec(19, 1, 0, 0, 5'b00100);
        set_vec(20, 1, 0, 0, 5'b01100);  // cnt6 tick
        set_vec(21, 1, 0, 0, 5'b10110);  // ratio 4 cnt0
        set_vec(22, 1, 0, 0, 5'b10110);
        set_vec(23, 1, 0, 0, 5'b00110);
        set_vec(24, 1, 0, 0, 5'b01110);  // cnt3 tick
        set_vec(25, 1, 0, 0, 5'b10110);

        repeat (2) @(posedge clk);
        do_reset("reset_state");
        cyc(0, 0, 0, 5'b00010, "off_idle");
        for (int i = 0; i < 26; i++)
            cyc(vecs[i].en, vecs[i].cv, vecs[i].n, vecs[i].exp, $sformatf("vec%0d", i));

        // en dropped at cnt1: period completes, then OFF; restart, then en blip before tick
        do_reset("reset_stop");
        cyc(1, 0, 0, 5'b10110, "stop_cnt0");
        cyc(1, 0, 0, 5'b10110, "stop_cnt1");
        cyc(0, 0, 0, 5'b10110, "stop_cnt2");
        cyc(0, 0, 0, 5'b00110, "stop_cnt3");
        cyc(0, 0, 0, 5'b00110, "stop_cnt4");
        cyc(0, 0, 0, 5'b00110, "stop_cnt5");
        cyc(0, 0, 0, 5'b01110, "stop_cnt6");
        cyc(0, 0, 0, 5'b00010, "stop_off");
        cyc(0, 0, 0, 5'b00010, "stop_off2");
        cyc(1, 0, 0, 5'b10110, "restart_cnt0");
        cyc(0, 0, 0, 5'b10110, "blip_cnt1");
        cyc(1, 0, 0, 5'b10110, "blip_cnt2");
        cyc(1, 0, 0, 5'b00110, "blip_cnt3");
        cyc(1, 0, 0, 5'b00110, "blip_cnt4");
        cyc(1, 0, 0, 5'b00110, "blip_cnt5");
        cyc(1, 0, 0, 5'b01110, "blip_cnt6");
        cyc(1, 0, 0, 5'b10110, "blip_wrap");

        // transfer on the tick cycle: one more full 7-period, then ratio 3
        do_reset("reset_tickxfer");
        cyc(1, 0, 0, 5'b10110, "tx_cnt0");
        for (int i = 1; i < 6; i++)
            cyc(1, 0, 0, (i < 3) ? 5'b10110 : 5'b00110, $sformatf("tx_cnt%0d", i));
        cyc(1, 0, 0, 5'b01110, "tx_cnt6");
        cyc(1, 1, 3, 5'b10100, "tx_pend_cnt0");
        for (int i = 1; i < 6; i++)
            cyc(1, 0, 0, (i < 3) ? 5'b10100 : 5'b00100, $sformatf("tx_pend_cnt%0d", i));
        cyc(1, 0, 0, 5'b01100, "tx_pend_cnt6");
        cyc(1, 0, 0, 5'b10110, "r3_cnt0");
        cyc(1, 0, 0, 5'b00110, "r3_cnt1");
        cyc(1, 0, 0, 5'b01110, "r3_cnt2");
        cyc(1, 0, 0, 5'b10110, "r3_wrap");

        // ratio loaded while OFF, minimum legal ratio 2
        do_reset("reset_off_load");
        cyc(0, 1, 2, 5'b00010, "off_load2");
        cyc(1, 0, 0, 5'b10110, "r2_cnt0");
        cyc(1, 0, 0, 5'b01110, "r2_cnt1");
        cyc(1, 0, 0, 5'b10110, "r2_cnt0b");

        // asynchronous reset while PEND mid-period drops outputs at once and loses the queued ratio
        do_reset("reset_pend");
        cyc(1, 0, 0, 5'b10110, "pr_cnt0");
        cyc(1, 1, 5, 5'b10100, "pr_cnt1_pend");
        cyc(1, 0, 0, 5'b10100, "pr_cnt2_pend");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 5'b00010);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0, 5'b10110, "post_cnt0");
        for (int i = 1; i < 6; i++)
            cyc(1, 0, 0, (i < 3) ? 5'b10110 : 5'b00110, $sformatf("post_cnt%0d", i));
        cyc(1, 0, 0, 5'b01110, "post_cnt6");
        cyc(1, 0, 0, 5'b10110, "post_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter N_RESET, default 7, divide ratio loaded at reset.
REQ-002 Parameter W, default 32, width of ratio bus and internal counter.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  run request; 1 = produce divided clock, 0 = stop at period end.
REQ-006 cfg_valid  in  1  new ratio offered on cfg_n.
REQ-007 cfg_n  in  W  requested divide ratio, unsigned.
REQ-008 cfg_ready  out  1  controller can accept a ratio this cycle.
REQ-009 cfg_err  out  1  one-cycle pulse: accepted ratio was illegal (<2), discarded.
REQ-010 n_clk  out  1  registered divided clock (clk / active ratio).
REQ-011 tick  out  1  one-cycle pulse on last clk cycle of each n_clk period.
REQ-012 busy  out  1  high while state is RUN or PEND.

Function
REQ-013 States: OFF (n_clk held 0), RUN (dividing), PEND (dividing, ratio update queued).
REQ-014 Counter cnt counts 0..n_act-1 in RUN/PEND, wraps to 0; tick = 1 when cnt == n_act-1.
REQ-015 n_clk = 1 when cnt < floor(n_act/2), else 0, registered; n=7 -> 3 high, 4 low; n=2 -> 1 high, 1 low.
REQ-016 Handshake: transfer when cfg_valid && cfg_ready; cfg_ready = 1 in OFF and RUN, 0 in PEND.
REQ-017 cfg_n < 2 on transfer: cfg_err pulses next cycle, n_act and state unchanged.
REQ-018 Legal transfer in OFF: n_act <= cfg_n next cycle, stay OFF.
REQ-019 Legal transfer in RUN: shadow <= cfg_n, RUN -> PEND.
REQ-020 PEND at tick: n_act <= shadow, cnt <= 0, PEND -> RUN (or OFF if en = 0); no truncated or stretched period ever emitted.
REQ-021 Transfer in RUN on a tick cycle: update queued, applied at the following tick, not the current one.
REQ-022 OFF with en = 1: RUN next cycle, cnt = 0, first n_clk high on that cycle.
REQ-023 en = 0 in RUN/PEND: current period completes; at tick -> OFF, pending ratio applied first.
REQ-024 en re-asserted before tick: no effect, divider continues uninterrupted.
REQ-025 Ratio arithmetic unsigned W-bit; ratio up to 2^W-1 supported without overflow.

Reset
REQ-026 On rst: state OFF, cnt 0, n_act N_RESET, shadow N_RESET, n_clk 0, tick 0, cfg_err 0, busy 0, cfg_ready 1.
REQ-027 rst mid-period or in PEND: queued ratio discarded, outputs to reset values immediately (asynchronous).
REQ-028 First RUN entry after reset release requires en = 1 sampled on a clk edge with rst = 0.

Structure
REQ-029 Package clk_div_pkg holds state enum (OFF, RUN, PEND), N_MIN = 2 constant, default W.
REQ-030 One sub-module div_counter (cnt, wrap, tick, n_clk generation from n_act); FSM and handshake in clk_div_ctrl.

Verification
REQ-031 rst, en = 1, no cfg -> n_clk period 70 ns at 10 ns clk, 30 ns high / 40 ns low, tick every 7th cycle.
REQ-032 In RUN at cnt = 2, cfg_n = 4 -> PEND, cfg_ready 0; remaining 4 cycles of the 7-period unchanged, then period 4 (2 high / 2 low).
REQ-033 cfg_n = 1 and cfg_n = 0 transfers -> cfg_err pulse each, ratio stays 7, state unchanged.
REQ-034 en dropped at cnt = 1 -> period completes (7 cycles total), then OFF, n_clk 0, busy 0; en re-raised -> restart at cnt 0.
REQ-035 cfg transfer exactly on tick cycle, cfg_n = 3 -> one more full 7-cycle period, then period 3.
REQ-036 rst asserted in PEND mid-period -> n_clk 0 immediately, n_act 7 after release, queued ratio lost.
